// File: rtl/tx_huge_page_sched_pkg.sv
// Shared definitions for the TX huge-page scheduler: FSM encoding, page
// geometry constants and the 4 KB-safe request length calculation.
package tx_huge_page_sched_pkg;

  localparam int unsigned PAGE_BOUNDARY_BYTES = 4096;
  localparam int unsigned QW_BYTES            = 8;

  // One-hot state encoding shared with the other engine FSMs.
  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_ISSUE    = 6'b000010,
    S_DRAIN    = 6'b000100,
    S_NOTIFY   = 6'b001000,
    S_RELEASE  = 6'b010000,
    S_WAIT_CLR = 6'b100000
  } sched_state_e;

  // Request length = min(rem, max_qw, qwords left before the next 4 KB line).
  // Intermediates are wide enough that neither the room nor the clamp wraps.
  function automatic logic [9:0] calc_len(input logic [11:0] page_off,
                                          input logic [31:0] rem,
                                          input logic [9:0]  max_qw);
    logic [12:0] room_bytes;
    logic [12:0] room_qw;
    logic [31:0] len;
    room_bytes = 13'(PAGE_BOUNDARY_BYTES) - {1'b0, page_off};
    room_qw    = room_bytes / 13'(QW_BYTES);
    len        = rem;
    if (len > 32'(max_qw))  len = 32'(max_qw);
    if (len > 32'(room_qw)) len = 32'(room_qw);
    return len[9:0];
  endfunction

endpackage

// File: rtl/tx_rd_chunker.sv
// Splits a page into 4 KB-safe read chunks. Holds the running pointer and
// remaining qword count; exposes the current chunk length and the chunk that
// follows it so the scheduler can present back-to-back requests.
module tx_rd_chunker
  import tx_huge_page_sched_pkg::*;
#(
  parameter int unsigned MAX_RD_QW = 64
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_qwords,
  input  logic        advance,
  output logic [63:0] ptr,
  output logic [31:0] rem,
  output logic [9:0]  len,
  output logic [63:0] nxt_ptr,
  output logic [31:0] nxt_rem,
  output logic [9:0]  nxt_len
);

  localparam logic [9:0] MAX_QW = 10'(MAX_RD_QW);

  // Current chunk and the chunk after it, derived from the pointer state.
  // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
  always_comb begin
    len     = calc_len(ptr[11:0], rem, MAX_QW);
    nxt_ptr = ptr + (64'(len) << 3);
    nxt_rem = rem - 32'(len);
    nxt_len = calc_len(nxt_ptr[11:0], nxt_rem, MAX_QW);
  end

  // Pointer/remainder: loaded at page start, stepped once per accepted request.
  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      rem <= '0;
    end else if (load) begin
      ptr <= load_addr;
      rem <= load_qwords;
    end else if (advance) begin
      ptr <= nxt_ptr;
      rem <= nxt_rem;
    end
  end

endmodule

// File: rtl/tx_huge_page_sched.sv
// Ping-pong scheduler for the two host TX huge pages: waits for the expected
// page to be unlocked, issues bounded DMA reads, counts completions, posts a
// notification and releases the page before moving to the other one.
module tx_huge_page_sched
  import tx_huge_page_sched_pkg::*;
#(
  parameter int unsigned MAX_RD_QW       = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic [31:0] huge_page_qwords_1,
  input  logic [31:0] huge_page_qwords_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic        huge_page_free_1,
  output logic        huge_page_free_2,
  input  logic [63:0] completed_buffer_address,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [63:0] rd_req_addr,
  output logic [9:0]  rd_req_qwords,
  input  logic        rd_cpl_done,
  output logic        notify_valid,
  input  logic        notify_ready,
  output logic [63:0] notify_addr,
  output logic [31:0] notify_data,
  output logic        busy
);

  localparam logic [3:0] OUTS_MAX = 4'(MAX_OUTSTANDING);

  sched_state_e state;
  logic         cur;
  logic [3:0]   outs;
  logic [3:0]   outs_next;
  logic [31:0]  total;

  logic        sel_status;
  logic [63:0] sel_addr;
  logic [31:0] sel_qwords;
  logic [31:0] note_qwords;
  logic        load;
  logic        hs;

  logic [63:0] ptr, nxt_ptr, ptr_after;
  logic [31:0] rem, nxt_rem;
  logic [9:0]  len, nxt_len, len_after;

  // Low address bits are defined as zero; the top qword bit is not reported.
  logic unused_bits;
  assign unused_bits = ^{sel_addr[2:0], note_qwords[31]};

  assign sel_status = cur ? huge_page_status_2 : huge_page_status_1;
  assign sel_addr   = cur ? huge_page_addr_2   : huge_page_addr_1;
  assign sel_qwords = cur ? huge_page_qwords_2 : huge_page_qwords_1;
  assign load       = (state == S_IDLE) && sel_status;
  assign hs         = rd_req_valid && rd_req_ready;
  assign busy       = (state != S_IDLE);

  tx_rd_chunker #(.MAX_RD_QW(MAX_RD_QW)) u_chunker (
    .trn_clk     (trn_clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_addr   ({sel_addr[63:3], 3'b000}),
    .load_qwords (sel_qwords),
    .advance     (hs),
    .ptr         (ptr),
    .rem         (rem),
    .len         (len),
    .nxt_ptr     (nxt_ptr),
    .nxt_rem     (nxt_rem),
    .nxt_len     (nxt_len)
  );

  // Next outstanding count and the request that should be presented next cycle.
  always_comb begin
    outs_next = outs;
    if (load) begin
      outs_next = '0;
    end else begin
      unique case ({hs, rd_cpl_done && (outs != 4'd0)})
        2'b10:   outs_next = outs + 4'd1;
        2'b01:   outs_next = outs - 4'd1;
        default: outs_next = outs;
      endcase
    end
    ptr_after   = hs ? nxt_ptr : ptr;
    len_after   = hs ? nxt_len : len;
    note_qwords = (state == S_IDLE) ? sel_qwords : total;
  end

  // Page FSM with registered request, notification and release outputs.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      cur              <= 1'b0;
      outs             <= '0;
      total            <= '0;
      rd_req_valid     <= 1'b0;
      rd_req_addr      <= '0;
      rd_req_qwords    <= '0;
      notify_valid     <= 1'b0;
      notify_addr      <= '0;
      notify_data      <= '0;
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;
    end else begin
      outs             <= outs_next;
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sel_status) begin
            total <= sel_qwords;
            if (sel_qwords == 32'd0) begin
              state        <= S_NOTIFY;
              notify_valid <= 1'b1;
              notify_addr  <= completed_buffer_address;
              notify_data  <= {cur, note_qwords[30:0]};
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (hs && (nxt_rem == 32'd0)) begin
            state        <= S_DRAIN;
            rd_req_valid <= 1'b0;
          end else begin
            rd_req_valid  <= (outs_next < OUTS_MAX);
            rd_req_addr   <= ptr_after;
            rd_req_qwords <= len_after;
          end
        end
        S_DRAIN: begin
          if (outs_next == 4'd0) begin
            state        <= S_NOTIFY;
            notify_valid <= 1'b1;
            notify_addr  <= completed_buffer_address;
            notify_data  <= {cur, note_qwords[30:0]};
          end
        end
        S_NOTIFY: begin
          if (notify_ready) begin
            state        <= S_RELEASE;
            notify_valid <= 1'b0;
            if (cur) huge_page_free_2 <= 1'b1;
            else     huge_page_free_1 <= 1'b1;
          end
        end
        S_RELEASE: begin
          state <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          if (!sel_status) begin
            cur   <= ~cur;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_huge_page_sched.sv
// Directed bench for tx_huge_page_sched. u_dut runs with MAX_OUTSTANDING=2;
// u_dut_o8 (defaults) shares all inputs and is used for the mid-drain reset.
module tb_tx_huge_page_sched;

  logic        trn_clk = 1'b0;
  logic        reset_n;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic [31:0] huge_page_qwords_1, huge_page_qwords_2;
  logic        huge_page_status_1, huge_page_status_2;
  logic [63:0] completed_buffer_address;
  logic        rd_req_ready, rd_cpl_done, notify_ready;

  logic        huge_page_free_1, huge_page_free_2;
  logic        rd_req_valid, notify_valid, busy;
  logic [63:0] rd_req_addr, notify_addr;
  logic [9:0]  rd_req_qwords;
  logic [31:0] notify_data;

  logic        o8_free_1, o8_free_2, o8_rd_req_valid, o8_notify_valid, o8_busy;
  logic [63:0] o8_rd_req_addr, o8_notify_addr;
  logic [9:0]  o8_rd_req_qwords;
  logic [31:0] o8_notify_data;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] req_addr_q[$];
  logic [9:0]  req_len_q[$];
  int          req_f1_q[$];
  int          free1_cnt = 0;
  int          free2_cnt = 0;
  int          o8_free_cnt = 0;
  int          o8_free_snap;

  always #5 trn_clk = ~trn_clk;

  tx_huge_page_sched #(.MAX_RD_QW(64), .MAX_OUTSTANDING(2)) u_dut (
    .trn_clk(trn_clk), .reset_n(reset_n),
    .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
    .huge_page_qwords_1(huge_page_qwords_1), .huge_page_qwords_2(huge_page_qwords_2),
    .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
    .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
    .completed_buffer_address(completed_buffer_address),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_qwords(rd_req_qwords),
    .rd_cpl_done(rd_cpl_done),
    .notify_valid(notify_valid), .notify_ready(notify_ready),
    .notify_addr(notify_addr), .notify_data(notify_data),
    .busy(busy)
  );

  tx_huge_page_sched u_dut_o8 (
    .trn_clk(trn_clk), .reset_n(reset_n),
    .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
    .huge_page_qwords_1(huge_page_qwords_1), .huge_page_qwords_2(huge_page_qwords_2),
    .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
    .huge_page_free_1(o8_free_1), .huge_page_free_2(o8_free_2),
    .completed_buffer_address(completed_buffer_address),
    .rd_req_valid(o8_rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(o8_rd_req_addr), .rd_req_qwords(o8_rd_req_qwords),
    .rd_cpl_done(rd_cpl_done),
    .notify_valid(o8_notify_valid), .notify_ready(notify_ready),
    .notify_addr(o8_notify_addr), .notify_data(o8_notify_data),
    .busy(o8_busy)
  );

  // Log accepted requests and release pulses mid-cycle, away from the clock edge.
  always @(negedge trn_clk) begin
    if (rd_req_valid && rd_req_ready) begin
      req_addr_q.push_back(rd_req_addr);
      req_len_q.push_back(rd_req_qwords);
      req_f1_q.push_back(free1_cnt);
    end
    if (huge_page_free_1) free1_cnt++;
    if (huge_page_free_2) free2_cnt++;
    if (o8_free_1 || o8_free_2) o8_free_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpl_pulse();
    rd_cpl_done = 1'b1;
    tick();
    rd_cpl_done = 1'b0;
  endtask

  task automatic wait_reqs(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (req_addr_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(req_addr_q.size()), 64'(n));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n                  = 1'b0;
    huge_page_addr_1         = '0;
    huge_page_addr_2         = '0;
    huge_page_qwords_1       = '0;
    huge_page_qwords_2       = '0;
    huge_page_status_1       = 1'b0;
    huge_page_status_2       = 1'b0;
    completed_buffer_address = '0;
    rd_req_ready             = 1'b0;
    rd_cpl_done              = 1'b0;
    notify_ready             = 1'b0;
    ticks(2);

    // Reset values
    check("rst_req_valid", 64'(rd_req_valid), 64'd0);
    check("rst_notify_valid", 64'(notify_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_free_1", 64'(huge_page_free_1), 64'd0);
    check("rst_free_2", 64'(huge_page_free_2), 64'd0);
    check("rst_req_addr", rd_req_addr, 64'd0);
    check("rst_req_qwords", 64'(rd_req_qwords), 64'd0);
    check("rst_notify_addr", notify_addr, 64'd0);
    check("rst_notify_data", 64'(notify_data), 64'd0);
    reset_n = 1'b1;
    tick();

    // Page 2 unlocked first must be ignored while page 1 is expected
    huge_page_addr_2         = 64'h8000;
    huge_page_qwords_2       = 32'd16;
    huge_page_status_2       = 1'b1;
    rd_req_ready             = 1'b1;
    completed_buffer_address = 64'hABCD_0000;
    ticks(4);
    check("p2_ignored_busy", 64'(busy), 64'd0);
    check("p2_ignored_reqs", 64'(req_addr_q.size()), 64'd0);

    // Page 1: 0x1000 / 100 qwords -> (0x1000,64) then (0x1200,36)
    huge_page_addr_1   = 64'h1000;
    huge_page_qwords_1 = 32'd100;
    huge_page_status_1 = 1'b1;
    tick();
    check("lat_cycle1_valid", 64'(rd_req_valid), 64'd0);
    check("lat_cycle1_busy", 64'(busy), 64'd1);
    tick();
    check("lat_cycle2_valid", 64'(rd_req_valid), 64'd1);
    wait_reqs("p1_req_count", 2, 20);
    check("p1_req0_addr", req_addr_q[0], 64'h1000);
    check("p1_req0_len", 64'(req_len_q[0]), 64'd64);
    check("p1_req1_addr", req_addr_q[1], 64'h1200);
    check("p1_req1_len", 64'(req_len_q[1]), 64'd36);
    ticks(3);
    check("p1_drain_no_notify", 64'(notify_valid), 64'd0);
    cpl_pulse();
    check("p1_one_cpl_no_notify", 64'(notify_valid), 64'd0);
    cpl_pulse();
    check("p1_notify_latency", 64'(notify_valid), 64'd1);
    completed_buffer_address = 64'hDEAD_BEEF_0000_0000;
    check("p1_notify_data", 64'(notify_data), 64'h0000_0064);
    check("p1_notify_addr", notify_addr, 64'hABCD_0000);
    ticks(2);
    check("p1_notify_hold", 64'(notify_valid), 64'd1);
    notify_ready = 1'b1;
    tick();
    check("p1_free_1_pulse", 64'(huge_page_free_1), 64'd1);
    check("p1_free_2_quiet", 64'(huge_page_free_2), 64'd0);
    tick();
    check("p1_free_1_one_cycle", 64'(huge_page_free_1), 64'd0);
    ticks(3);
    check("p1_wait_clr_busy", 64'(busy), 64'd1);
    check("p1_free_1_count", 64'(free1_cnt), 64'd1);
    check("p1_no_reaccept", 64'(req_addr_q.size()), 64'd2);
    huge_page_status_1 = 1'b0;

    // Page 2 follows only after page 1 has been released
    wait_reqs("p2_req_count", 3, 20);
    check("p2_req_addr", req_addr_q[2], 64'h8000);
    check("p2_req_len", 64'(req_len_q[2]), 64'd16);
    check("p2_after_free_1", 64'(req_f1_q[2]), 64'd1);
    ticks(2);
    cpl_pulse();
    check("p2_notify_valid", 64'(notify_valid), 64'd1);
    check("p2_notify_data", 64'(notify_data), 64'h8000_0010);
    check("p2_notify_addr", notify_addr, 64'hDEAD_BEEF_0000_0000);
    tick();
    check("p2_free_2_pulse", 64'(huge_page_free_2), 64'd1);
    huge_page_status_2 = 1'b0;
    ticks(3);
    check("p2_back_idle", 64'(busy), 64'd0);

    // Page 1 near a 4 KB line: 0x1FF0 / 10 -> (0x1FF0,2) then (0x2000,8)
    req_addr_q.delete();
    req_len_q.delete();
    req_f1_q.delete();
    huge_page_addr_1   = 64'h1FF0;
    huge_page_qwords_1 = 32'd10;
    huge_page_status_1 = 1'b1;
    wait_reqs("b4k_req_count", 2, 20);
    check("b4k_req0_addr", req_addr_q[0], 64'h1FF0);
    check("b4k_req0_len", 64'(req_len_q[0]), 64'd2);
    check("b4k_req1_addr", req_addr_q[1], 64'h2000);
    check("b4k_req1_len", 64'(req_len_q[1]), 64'd8);
    ticks(2);
    cpl_pulse();
    cpl_pulse();
    check("b4k_notify_valid", 64'(notify_valid), 64'd1);
    check("b4k_notify_data", 64'(notify_data), 64'h0000_000A);
    tick();
    check("b4k_free_1_pulse", 64'(huge_page_free_1), 64'd1);
    huge_page_status_1 = 1'b0;
    ticks(2);

    // Empty page: no read, still notified and released
    apply_reset();
    req_addr_q.delete();
    req_len_q.delete();
    req_f1_q.delete();
    huge_page_addr_1   = 64'h3000;
    huge_page_qwords_1 = 32'd0;
    huge_page_status_1 = 1'b1;
    tick();
    check("zero_notify_valid", 64'(notify_valid), 64'd1);
    check("zero_notify_data", 64'(notify_data), 64'd0);
    check("zero_req_valid", 64'(rd_req_valid), 64'd0);
    tick();
    check("zero_free_1_pulse", 64'(huge_page_free_1), 64'd1);
    check("zero_no_reqs", 64'(req_addr_q.size()), 64'd0);
    huge_page_status_1 = 1'b0;
    ticks(2);

    // Outstanding limit of 2 with completions withheld
    apply_reset();
    req_addr_q.delete();
    req_len_q.delete();
    req_f1_q.delete();
    notify_ready       = 1'b0;
    huge_page_addr_1   = 64'h0;
    huge_page_qwords_1 = 32'd256;
    huge_page_status_1 = 1'b1;
    ticks(12);
    check("outs_limit_count", 64'(req_addr_q.size()), 64'd2);
    check("outs_limit_valid", 64'(rd_req_valid), 64'd0);
    cpl_pulse();
    ticks(5);
    check("outs_release_one", 64'(req_addr_q.size()), 64'd3);
    check("outs_req2_addr", req_addr_q[2], 64'h400);

    // Second instance now in DRAIN with 3 outstanding: asynchronous reset
    check("o8_drain_busy", 64'(o8_busy), 64'd1);
    check("o8_drain_req_valid", 64'(o8_rd_req_valid), 64'd0);
    o8_free_snap = o8_free_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_o8_busy", 64'(o8_busy), 64'd0);
    check("arst_o8_req_addr", o8_rd_req_addr, 64'd0);
    check("arst_o8_req_qwords", 64'(o8_rd_req_qwords), 64'd0);
    check("arst_o8_notify_valid", 64'(o8_notify_valid), 64'd0);
    check("arst_o8_notify_data", 64'(o8_notify_data), 64'd0);
    check("arst_o8_free", 64'({o8_free_1, o8_free_2}), 64'd0);
    check("arst_main_req_valid", 64'(rd_req_valid), 64'd0);
    huge_page_status_1 = 1'b0;
    huge_page_addr_2   = 64'h9000;
    huge_page_qwords_2 = 32'd4;
    huge_page_status_2 = 1'b1;
    ticks(2);
    reset_n = 1'b1;
    ticks(5);
    check("post_rst_cur0_busy", 64'(o8_busy), 64'd0);
    check("post_rst_no_free", 64'(o8_free_cnt), 64'(o8_free_snap));
    huge_page_qwords_1 = 32'd0;
    huge_page_status_1 = 1'b1;
    ticks(2);
    check("post_rst_page1_taken", 64'(o8_busy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
